// File: rtl/vga_scanout_if.sv
// Pixel write channel into the scan-out line buffer: valid/ready handshake
// carrying one {r,g,b} pixel per accepted transfer.
interface vga_scanout_if #(
    parameter int CH_W = 4
);
    logic                w_valid;
    logic [3*CH_W-1:0]   w_data;
    logic                w_ready;

    modport master (
        output w_valid,
        output w_data,
        input  w_ready
    );

    modport slave (
        input  w_valid,
        input  w_data,
        output w_ready
    );
endinterface

// File: rtl/vga_scanout.sv
// Single-clock VGA scan-out: timing generator, two-bank line buffer and
// integer pixel replication driven by a valid/ready pixel writer.
module vga_scanout #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 40,
    parameter int H_BACK    = 128,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 9,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 28,
    parameter int SCALE     = 5,
    parameter int CH_W      = 4,
    parameter int PIX_DIV   = 1,
    parameter bit H_POL     = 1'b1,
    parameter bit V_POL     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    vga_scanout_if.slave      wr,
    input  logic              underflow_clr,
    output logic              underflow,
    output logic              frame_start,
    output logic              Hsync,
    output logic              Vsync,
    output logic [CH_W-1:0]   VGA_r,
    output logic [CH_W-1:0]   VGA_g,
    output logic [CH_W-1:0]   VGA_b
);
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int BUF_WIDTH = H_DISPLAY / SCALE;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int AW = (BUF_WIDTH > 1) ? $clog2(BUF_WIDTH) : 1;
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DISP     = HW'(H_DISPLAY);
    localparam logic [HW-1:0] H_COL_LAST = HW'(H_DISPLAY - 1);
    localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DISP     = VW'(V_DISPLAY);
    localparam logic [VW-1:0] V_DISP_M1  = VW'(V_DISPLAY - 1);
    localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST   = DW'(PIX_DIV - 1);
    localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(BUF_WIDTH - 1);

    logic [DW-1:0]       div;
    logic [HW-1:0]       h;
    logic [VW-1:0]       v;
    logic [SW-1:0]       col_sub, line_sub;
    logic [AW-1:0]       rd_addr, w_addr;
    logic                w_bank, r_bank, grp_ok;
    logic [1:0]          full, full_nxt;
    logic [3*CH_W-1:0]   mem [2][BUF_WIDTH];

    logic tick, h_end, v_disp, disp, nv_disp, nsub0;
    logic grp_check, grp_rel, chk_bank, accept, w_done;

    assign tick    = (div == DIV_LAST);
    assign h_end   = tick && (h == H_LAST);
    assign v_disp  = (v < V_DISP);
    assign disp    = (h < H_DISP) && v_disp;
    assign nv_disp = (v == V_LAST) || (v < V_DISP_M1);
    assign nsub0   = v_disp ? (line_sub == SUB_LAST) : 1'b1;

    assign grp_check = h_end && nv_disp && nsub0;
    assign grp_rel   = h_end && v_disp && (line_sub == SUB_LAST) && grp_ok;
    // A release and the next group's check share a tick; check the bank that
    // will be read next, not the one being freed.
    assign chk_bank  = r_bank ^ grp_rel;

    assign wr.w_ready = ~full[w_bank];
    assign accept     = wr.w_valid && wr.w_ready;
    assign w_done     = accept && (w_addr == ADDR_LAST);

    always_comb begin
        full_nxt = full;
        if (grp_rel) full_nxt[r_bank] = 1'b0;
        if (w_done)  full_nxt[w_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[w_bank][w_addr] <= wr.w_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            col_sub     <= '0;
            line_sub    <= '0;
            rd_addr     <= '0;
            w_addr      <= '0;
            w_bank      <= 1'b0;
            r_bank      <= 1'b0;
            full        <= '0;
            grp_ok      <= 1'b0;
            underflow   <= 1'b0;
            frame_start <= 1'b0;
            Hsync       <= ~H_POL;
            Vsync       <= ~V_POL;
            VGA_r       <= '0;
            VGA_g       <= '0;
            VGA_b       <= '0;
        end else begin
            full        <= full_nxt;
            frame_start <= tick && (h == '0) && (v == '0);

            if (accept) begin
                w_addr <= w_done ? '0 : w_addr + AW'(1);
                if (w_done) w_bank <= ~w_bank;
            end

            if (grp_check && !full[chk_bank]) underflow <= 1'b1;
            else if (underflow_clr)           underflow <= 1'b0;
            if (grp_check) grp_ok <= full[chk_bank];
            if (grp_rel)   r_bank <= ~r_bank;

            div <= tick ? '0 : div + DW'(1);

            if (tick) begin
                h <= h_end ? '0 : h + HW'(1);
                if (h_end) begin
                    v <= (v == V_LAST) ? '0 : v + VW'(1);
                    if (v_disp) line_sub <= (line_sub == SUB_LAST) ? '0 : line_sub + SW'(1);
                end

                // rd_addr stops at the last column so it never leaves the bank.
                if (h_end) begin
                    col_sub <= '0;
                    rd_addr <= '0;
                end else if (h < H_DISP) begin
                    if (col_sub == SUB_LAST) begin
                        col_sub <= '0;
                        if (h < H_COL_LAST) rd_addr <= rd_addr + AW'(1);
                    end else begin
                        col_sub <= col_sub + SW'(1);
                    end
                end

                Hsync <= (h >= H_SYNC_ON && h < H_SYNC_OFF) ? H_POL : ~H_POL;
                Vsync <= (v >= V_SYNC_ON && v < V_SYNC_OFF) ? V_POL : ~V_POL;
                {VGA_r, VGA_g, VGA_b} <= (disp && grp_ok) ? mem[r_bank][rd_addr] : '0;
            end
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a 12x7 timing, SCALE 2, plus a PIX_DIV=3
// instance for tick/frame-rate behaviour.
module tb_vga_scanout;
    logic        clk = 1'b0;
    logic        rst;
    logic        underflow_clr;
    logic        underflow, frame_start, hs, vs;
    logic [3:0]  r, g, b;
    logic        underflow3, frame_start3, hs3, vs3;
    logic [3:0]  r3, g3, b3;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vga_scanout_if #(.CH_W(4)) wif ();
    vga_scanout_if #(.CH_W(4)) wif3 ();

    vga_scanout #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SCALE(2), .CH_W(4), .PIX_DIV(1), .H_POL(1'b1), .V_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .wr(wif), .underflow_clr(underflow_clr),
        .underflow(underflow), .frame_start(frame_start),
        .Hsync(hs), .Vsync(vs), .VGA_r(r), .VGA_g(g), .VGA_b(b)
    );

    vga_scanout #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SCALE(2), .CH_W(4), .PIX_DIV(3), .H_POL(1'b1), .V_POL(1'b1)
    ) dut3 (
        .clk(clk), .rst(rst), .wr(wif3), .underflow_clr(1'b0),
        .underflow(underflow3), .frame_start(frame_start3),
        .Hsync(hs3), .Vsync(vs3), .VGA_r(r3), .VGA_g(g3), .VGA_b(b3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Inputs presented before clock edge n (counted from reset release).
    task automatic drive_for(input int n);
        wif.w_valid   = 1'b0;
        wif.w_data    = '0;
        underflow_clr = 1'b0;
        if (n >= 1 && n <= 8) begin
            wif.w_valid = 1'b1; wif.w_data = 12'h123 + 12'(n - 1);
        end else if (n >= 170 && n <= 173) begin
            wif.w_valid = 1'b1; wif.w_data = 12'hA10 + 12'(n - 170);
        end else if (n >= 200 && n <= 202) begin
            wif.w_valid = 1'b1; wif.w_data = 12'hB20 + 12'(n - 200);
        end else if (n == 216) begin
            wif.w_valid = 1'b1; wif.w_data = 12'hB23;
        end
        if (n == 141) underflow_clr = 1'b1;
    endtask

    initial begin
        int p, f, rr, vv, hh, q;
        logic [11:0] e_col;
        logic [1:0]  e_full;
        logic        e_uf, e_rdy, e_rb, e_hs3;

        rst = 1'b1;
        wif3.w_valid = 1'b0;
        wif3.w_data  = '0;
        drive_for(0);
        repeat (2) @(negedge clk);

        chk("rst_hsync", 32'(hs), 32'(0));
        chk("rst_vsync", 32'(vs), 32'(0));
        chk("rst_colour", 32'({r, g, b}), 32'(0));
        chk("rst_underflow", 32'(underflow), 32'(0));
        chk("rst_frame_start", 32'(frame_start), 32'(0));
        chk("rst_w_ready", 32'(wif.w_ready), 32'(1));

        drive_for(1);
        rst = 1'b0;

        for (int k = 1; k <= 257; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc = k;
            p  = k - 1;
            f  = p / 84;
            rr = p % 84;
            vv = rr / 12;
            hh = rr % 12;

            e_col = '0;
            if (hh < 8) begin
                if (f == 0 && (vv == 2 || vv == 3)) e_col = 12'h123 + 12'(hh / 2);
                if (f == 1 && vv <= 1)              e_col = 12'h127 + 12'(hh / 2);
                if (f == 2 && (vv == 2 || vv == 3)) e_col = 12'hA10 + 12'(hh / 2);
                if (f == 3 && vv <= 1)              e_col = 12'hB20 + 12'(hh / 2);
            end
            if (k < 4)        e_full = 2'b00;
            else if (k < 8)   e_full = 2'b01;
            else if (k < 48)  e_full = 2'b11;
            else if (k < 108) e_full = 2'b10;
            else if (k < 173) e_full = 2'b00;
            else if (k < 216) e_full = 2'b01;
            else              e_full = 2'b10;
            e_uf  = (k >= 108 && k <= 140) || (k >= 168);
            e_rdy = !(k >= 8 && k <= 47);
            e_rb  = (k >= 48 && k < 108) || (k >= 216);

            chk("colour", 32'({r, g, b}), 32'(e_col));
            chk("hsync", 32'(hs), 32'(hh == 9 || hh == 10));
            chk("vsync", 32'(vs), 32'(vv == 5));
            chk("frame_start", 32'(frame_start), 32'(rr == 0));
            chk("underflow", 32'(underflow), 32'(e_uf));
            chk("w_ready", 32'(wif.w_ready), 32'(e_rdy));
            chk("full", 32'(dut.full), 32'(e_full));
            chk("r_bank", 32'(dut.r_bank), 32'(e_rb));

            if (k <= 256) begin
                q = k / 3 - 1;
                e_hs3 = (k >= 3) && ((q % 12) == 9 || (q % 12) == 10);
                chk("div3_hsync", 32'(hs3), 32'(e_hs3));
                chk("div3_frame_start", 32'(frame_start3), 32'(k == 3 || k == 255));
            end

            drive_for(k + 1);
        end

        // Mid-line reset with bank 1 still full.
        rst = 1'b1;
        #1;
        chk("mid_rst_hsync", 32'(hs), 32'(0));
        chk("mid_rst_vsync", 32'(vs), 32'(0));
        chk("mid_rst_colour", 32'({r, g, b}), 32'(0));
        chk("mid_rst_underflow", 32'(underflow), 32'(0));
        chk("mid_rst_frame_start", 32'(frame_start), 32'(0));
        chk("mid_rst_full", 32'(dut.full), 32'(0));
        chk("mid_rst_w_ready", 32'(wif.w_ready), 32'(1));
        chk("mid_rst_h", 32'(dut.h), 32'(0));
        chk("mid_rst_v", 32'(dut.v), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_frame_start", 32'(frame_start), 32'(1));
        chk("post_rst_colour", 32'({r, g, b}), 32'(0));
        chk("post_rst_w_ready", 32'(wif.w_ready), 32'(1));
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_frame_start_low", 32'(frame_start), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
